// File: rtl/parity_frame_sched_pkg.sv
// rtl/parity_frame_sched_pkg.sv - shared types, constants and round-robin search for the parity scheduler
package parity_sched_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    REPORT = 2'd2
  } state_e;

  // First set bit of vld at or after ptr, wrapping modulo nreq (nreq <= 8).
  function automatic int rr_pick(input logic [7:0] vld, input int ptr, input int nreq);
    int idx;
    rr_pick = ptr;
    for (int k = nreq - 1; k >= 0; k--) begin
      idx = (ptr + k) % nreq;
      if (vld[idx[2:0]]) rr_pick = idx;
    end
  endfunction

endpackage

// File: rtl/parity_frame_sched_if.sv
// rtl/parity_frame_sched_if.sv - requester word streams and result record bundle
interface parity_frame_sched_if
  import parity_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 8
) ();

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*WORD_W-1:0] req_data;
  logic [NREQ-1:0]        req_last;
  logic [NREQ-1:0]        req_exp;
  logic [NREQ-1:0]        req_ready;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic                   res_parity;
  logic                   res_err;
  logic                   res_len_err;
  logic [CNT_W-1:0]       res_words;
  logic                   busy;

  modport master (
    output req_valid, req_data, req_last, req_exp, res_ready,
    input  req_ready, res_valid, res_id, res_parity, res_err, res_len_err, res_words, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, req_exp, res_ready,
    output req_ready, res_valid, res_id, res_parity, res_err, res_len_err, res_words, busy
  );

endinterface

// File: rtl/parity_frame_sched_parity_tree16.sv
// rtl/parity_frame_sched_parity_tree16.sv - four-level balanced XOR tree over one 16-bit word
module parity_tree16 (
  input  logic [15:0] data_i,
  output logic        p_o
);

  logic [7:0] l1;
  logic [3:0] l2;
  logic [1:0] l3;

  assign l1  = data_i[15:8] ^ data_i[7:0];
  assign l2  = l1[7:4] ^ l1[3:0];
  assign l3  = l2[3:2] ^ l2[1:0];
  assign p_o = l3[1] ^ l3[0];

endmodule

// File: rtl/parity_frame_sched.sv
// rtl/parity_frame_sched.sv - round-robin frame parity checker sharing one XOR tree across requesters
module parity_frame_sched
  import parity_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int MAX_LEN = 16,
  parameter int CNT_W   = 8,
  parameter int ODD     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  parity_frame_sched_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   grant_q, grant_d;
  logic [ID_W-1:0]   rr_q, rr_d;
  logic              acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              par_q, par_d;
  logic              err_q, err_d;
  logic              len_q, len_d;
  logic [CNT_W-1:0]  words_q, words_d;

  logic [WORD_W-1:0] cur_word;
  logic              cur_valid, cur_last, cur_exp;
  logic              word_p, acc_nxt, par_fin, len_fin;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        vld8;

  // Steer the granted requester's lane onto the shared datapath.
  always_comb begin
    cur_word  = '0;
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_exp   = 1'b0;
    for (int r = 0; r < NREQ; r++) begin
      if (grant_q == ID_W'(r)) begin
        cur_word  = bus.req_data[r*WORD_W +: WORD_W];
        cur_valid = bus.req_valid[r];
        cur_last  = bus.req_last[r];
        cur_exp   = bus.req_exp[r];
      end
    end
    vld8 = '0;
    vld8[NREQ-1:0] = bus.req_valid;
  end

  parity_tree16 u_tree (
    .data_i (cur_word),
    .p_o    (word_p)
  );

  assign cnt_inc = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
  assign acc_nxt = acc_q ^ word_p;
  assign par_fin = acc_nxt ^ (ODD != 0);
  assign len_fin = (cnt_inc > CNT_MAX);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    err_d   = err_q;
    len_d   = len_q;
    words_d = words_q;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_d = ID_W'(rr_pick(vld8, int'(rr_q), NREQ));
          acc_d   = 1'b0;
          cnt_d   = '0;
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (cur_valid) begin
          acc_d = acc_nxt;
          cnt_d = cnt_inc;
          if (cur_last) begin
            par_d   = par_fin;
            len_d   = len_fin;
            err_d   = (par_fin != cur_exp) | len_fin;
            words_d = cnt_inc;
            state_d = REPORT;
          end
        end
      end
      REPORT: begin
        if (bus.res_ready) begin
          rr_d    = (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      acc_q   <= 1'b0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      err_q   <= 1'b0;
      len_q   <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      err_q   <= err_d;
      len_q   <= len_d;
      words_q <= words_d;
    end
  end

  always_comb begin
    bus.req_ready = '0;
    for (int r = 0; r < NREQ; r++) begin
      bus.req_ready[r] = (state_q == STREAM) && (grant_q == ID_W'(r));
    end
  end

  assign bus.res_valid   = (state_q == REPORT);
  assign bus.busy        = (state_q != IDLE);
  assign bus.res_id      = grant_q;
  assign bus.res_parity  = par_q;
  assign bus.res_err     = err_q;
  assign bus.res_len_err = len_q;
  assign bus.res_words   = words_q;

endmodule

// File: doc/parity_frame_sched.md
Name: parity_frame_sched

Overview:
- Time-shares one 16-input XOR parity tree between NREQ requesters.
- Each requester streams a frame of 16-bit words; the block accumulates frame parity across the words.
- At the end of each frame it compares the accumulated parity with the requester's expected bit and reports one result record per frame.
- Sits between the link-level frame sources and the error-reporting unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester-id width; must equal clog2(NREQ).
- MAX_LEN, 16, maximum words per frame (1..255).
- CNT_W, 8, word-counter width; must hold MAX_LEN+1.
- ODD, 0, 0 selects even parity (parity = XOR of all bits); 1 selects odd parity (parity = inverted XOR).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*16  per-requester word; requester r uses bits [16r+15:16r].
- req_last  in  NREQ  marks the final word of the frame.
- req_exp  in  NREQ  expected frame parity; sampled only with the last word.
- req_ready  out  NREQ  word accept; one-hot or zero.
- res_valid  out  1  result record valid.
- res_ready  in  1  result consumer ready.
- res_id  out  ID_W  requester the result belongs to.
- res_parity  out  1  accumulated frame parity (after ODD inversion).
- res_err  out  1  res_parity != expected, OR a length error.
- res_len_err  out  1  frame exceeded MAX_LEN words.
- res_words  out  CNT_W  number of words accepted in the frame.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, rst_n=0) clears everything:
  - state=IDLE; all outputs 0; round-robin pointer=0; accumulator=0; counter=0.
- Word handshake: a word is accepted when req_valid[g] & req_ready[g] are both high. Result handshake: a result transfers when res_valid & res_ready are both high.
- Word parity: p = XOR of the 16 data bits, computed combinationally. acc_next = acc ^ p.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the rr pointer (wrapping).
  - Register the grant index g, clear acc and the counter, go to STREAM.
  - No req_ready is driven in IDLE, so one grant cycle of latency applies.
- STREAM:
  - req_ready[g]=1; all other ready bits are 0.
  - One word per cycle on each accepted beat: acc^=p; counter increments and saturates at MAX_LEN+1.
  - On an accepted last word:
    - latch res_parity = acc_final ^ ODD;
    - latch res_len_err = (counter_after > MAX_LEN);
    - latch res_err = (res_parity != req_exp[g]) | res_len_err;
    - latch res_words = counter_after, capped at MAX_LEN+1;
    - go to REPORT.
  - A word of length 1 (last on the first word) is legal.
  - Words beyond MAX_LEN are still accepted and XORed. The length error is reported only when the last word arrives; the frame is not truncated.
  - A deasserted req_valid[g] stalls the frame; grant is held and there is no timeout.
- REPORT:
  - res_valid=1 and all req_ready=0.
  - Result fields stay stable until res_ready.
  - On the result transfer: rr pointer = (g+1) mod NREQ; go to IDLE. If res_ready is already high on REPORT entry, res_valid is high for exactly one cycle.
- Result latency: res_valid rises on the cycle after the last word is accepted.
- Minimum frame throughput is N+2 cycles for N words (grant, N beats, report).
- Fairness: a requester that keeps requesting waits at most NREQ-1 frames.
- Simultaneous requests resolve by the rr pointer only. Requests from non-granted requesters are ignored and left pending; req_valid must stay asserted per valid/ready convention.
- Reset mid-frame or mid-report drops the frame immediately; no result is emitted.

Decomposition:
- Package parity_sched_pkg holds:
  - state enum {IDLE, STREAM, REPORT};
  - WORD_W=16 constant;
  - helper function for the round-robin next-index search.
- Sub-module parity_tree16: purely combinational 16-input balanced XOR tree, 4 levels, data[15:0] -> p. It is the only parity datapath, instantiated once.

Test Plan:
- Single requester 0, frame of 3 words 0x0001, 0x0003, 0x0000, last on the third, exp=1, ODD=0 -> one result: res_id=0, res_parity=1, res_err=0, res_words=3; res_valid rises the cycle after the third accept.
- Same frame with exp=0 -> res_err=1, res_len_err=0. With ODD=1 and exp=0 -> res_parity=0, res_err=0.
- Requesters 1 and 3 both valid from reset, each sending 1-word frames of 0xFFFF and 0x8000 -> grants occur in order 1 then 3. Results: id=1 parity=0; id=3 parity=1. The rr pointer ends at 0.
- Requester 2 sends a frame of MAX_LEN+2=18 words -> all 18 accepted; res_len_err=1, res_err=1, res_words=17 (saturated).
- res_ready held low for 5 cycles in REPORT -> res_valid and all result fields stable; req_ready stays 0 and no new grant is issued until the transfer.
- rst_n pulsed low mid-STREAM after 2 words -> outputs clear immediately (asynchronously). After release, the next frame starts with acc=0 and count=0, and no stale result appears.
